// File: rtl/avl_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM pipelined-burst master between two requesters.
// Read responses are steered back in order through a FIFO of {requester, burstcount}.
module avl_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 27,
  parameter int unsigned DATA_WIDTH    = 576,
  parameter int unsigned RD_FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [ADDR_WIDTH-1:0]   s0_address,
  input  logic                    s0_read,
  input  logic                    s0_write,
  input  logic [DATA_WIDTH-1:0]   s0_writedata,
  input  logic [DATA_WIDTH/8-1:0] s0_be,
  input  logic [6:0]              s0_burstcount,
  output logic                    s0_waitrequest,
  output logic [DATA_WIDTH-1:0]   s0_readdata,
  output logic                    s0_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  input  logic [DATA_WIDTH/8-1:0] s1_be,
  input  logic [6:0]              s1_burstcount,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,

  output logic [ADDR_WIDTH-1:0]   m0_address,
  output logic                    m0_read,
  output logic                    m0_write,
  output logic [DATA_WIDTH-1:0]   m0_writedata,
  output logic [DATA_WIDTH/8-1:0] m0_be,
  output logic [6:0]              m0_burstcount,
  input  logic                    m0_waitrequest,
  input  logic [DATA_WIDTH-1:0]   m0_readdata,
  input  logic                    m0_readdatavalid,

  output logic                    err_orphan_rdv
);

  localparam int unsigned PtrWidth = $clog2(RD_FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StCmd, StWburst} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [6:0]        wcnt_q, wcnt_d;
  logic [6:0]        rcnt_q;
  logic [PtrWidth:0] wptr_q, rptr_q;
  logic              err_q;

  logic              fifo_id [RD_FIFO_DEPTH];
  logic [6:0]        fifo_bc [RD_FIFO_DEPTH];

  logic              sel;
  logic              sel_read, sel_write;
  logic [6:0]        sel_bc, sel_bc_eff;
  logic              active, rd_stall, accept, push, pop, route;
  logic              fifo_full, fifo_empty;
  logic              head_id;
  logic [6:0]        head_bc;
  logic              elig0, elig1;

  // Outside a grant the command mux parks on the last winner.
  assign sel        = (state_q == StIdle) ? last_q : gnt_q;
  assign sel_read   = sel ? s1_read : s0_read;
  assign sel_write  = sel ? s1_write : s0_write;
  assign sel_bc     = sel ? s1_burstcount : s0_burstcount;
  assign sel_bc_eff = (sel_bc == 7'd0) ? 7'd1 : sel_bc;

  assign m0_address    = sel ? s1_address : s0_address;
  assign m0_writedata  = sel ? s1_writedata : s0_writedata;
  assign m0_be         = sel ? s1_be : s0_be;
  assign m0_burstcount = sel_bc;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrWidth] != rptr_q[PtrWidth]) &&
                      (wptr_q[PtrWidth-1:0] == rptr_q[PtrWidth-1:0]);
  assign head_id    = fifo_id[rptr_q[PtrWidth-1:0]];
  assign head_bc    = fifo_bc[rptr_q[PtrWidth-1:0]];

  assign route  = m0_readdatavalid & ~fifo_empty & ~reset;
  assign pop    = route & (rcnt_q == head_bc - 7'd1);
  assign active = (state_q != StIdle) & ~reset;
  assign accept = (m0_read | m0_write) & ~m0_waitrequest;
  assign push   = accept & m0_read;

  assign s0_readdata      = m0_readdata;
  assign s1_readdata      = m0_readdata;
  assign s0_readdatavalid = route & ~head_id;
  assign s1_readdatavalid = route & head_id;
  assign err_orphan_rdv   = err_q;

  assign elig0 = s0_write | (s0_read & ~fifo_full);
  assign elig1 = s1_write | (s1_read & ~fifo_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      wcnt_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (elig0 && elig1) begin
          gnt_d   = ~last_q;
          state_d = StCmd;
        end else if (elig0 || elig1) begin
          gnt_d   = elig1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (accept) begin
          if (m0_write && sel_bc_eff > 7'd1) begin
            wcnt_d  = sel_bc_eff - 7'd1;
            state_d = StWburst;
          end else begin
            last_d  = gnt_q;
            state_d = StIdle;
          end
        end
      end
      StWburst: begin
        if (accept) begin
          wcnt_d = wcnt_q - 7'd1;
          if (wcnt_q == 7'd1) begin
            last_d  = gnt_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reads only launch from CMD; during a write burst the requester owns m0 for writes only.
  always_comb begin
    rd_stall = 1'b0;
    m0_read  = 1'b0;
    m0_write = 1'b0;
    if (active) begin
      if (state_q == StCmd) begin
        rd_stall = sel_read & ~sel_write & fifo_full & ~pop;
        m0_read  = sel_read & ~sel_write & ~rd_stall;
      end
      m0_write = sel_write;
    end
    s0_waitrequest = ~(active & ~gnt_q) | rd_stall | m0_waitrequest;
    s1_waitrequest = ~(active & gnt_q) | rd_stall | m0_waitrequest;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      rcnt_q <= 7'd0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_q + {{PtrWidth{1'b0}}, push};
      rptr_q <= rptr_q + {{PtrWidth{1'b0}}, pop};
      if (route) begin
        rcnt_q <= pop ? 7'd0 : rcnt_q + 7'd1;
      end
      if (m0_readdatavalid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wptr_q[PtrWidth-1:0]] <= gnt_q;
      fifo_bc[wptr_q[PtrWidth-1:0]] <= sel_bc_eff;
    end
  end

endmodule

// File: tb/tb_avl_rr_arbiter.sv
// Bench for avl_rr_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level model of arbitration and read routing.
module tb_avl_rr_arbiter;
  localparam int AW    = 27;
  localparam int DW    = 64;
  localparam int BW    = DW / 8;
  localparam int Depth = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [1:0][AW-1:0]   s_addr;
  logic [1:0]           s_read, s_write;
  logic [1:0][DW-1:0]   s_wdata;
  logic [1:0][BW-1:0]   s_be;
  logic [1:0][6:0]      s_bc;
  logic                 s0_wait, s1_wait, s0_rdv, s1_rdv;
  logic [DW-1:0]        s0_rdata, s1_rdata;
  logic [AW-1:0]        m0_address;
  logic                 m0_read, m0_write;
  logic [DW-1:0]        m0_wdata;
  logic [BW-1:0]        m0_be;
  logic [6:0]           m0_bc;
  logic                 m0_wait, m0_rdv;
  logic [DW-1:0]        m0_rdata;
  logic                 err;

  avl_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_FIFO_DEPTH(Depth)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s_addr[0]), .s0_read(s_read[0]), .s0_write(s_write[0]),
    .s0_writedata(s_wdata[0]), .s0_be(s_be[0]), .s0_burstcount(s_bc[0]),
    .s0_waitrequest(s0_wait), .s0_readdata(s0_rdata), .s0_readdatavalid(s0_rdv),
    .s1_address(s_addr[1]), .s1_read(s_read[1]), .s1_write(s_write[1]),
    .s1_writedata(s_wdata[1]), .s1_be(s_be[1]), .s1_burstcount(s_bc[1]),
    .s1_waitrequest(s1_wait), .s1_readdata(s1_rdata), .s1_readdatavalid(s1_rdv),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_wdata), .m0_be(m0_be), .m0_burstcount(m0_bc),
    .m0_waitrequest(m0_wait), .m0_readdata(m0_rdata), .m0_readdatavalid(m0_rdv),
    .err_orphan_rdv(err)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase 0 = arbitrating, 1 = owner's first beat pending, 2 = rest of a write burst.
  typedef struct {bit id; int left;} rd_t;
  rd_t  mq[$];
  int   ph = 0;
  bit   own = 1'b0, lst = 1'b1, merr = 1'b0;
  int   wleft = 0;
  logic e_rd, e_wr;
  logic [1:0] e_wait, e_rdv;

  // Random requester state
  bit rq_act[2], rq_first[2];
  int rq_kind[2], rq_bc[2], rq_left[2];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check();
    bit src, w, r, stall, popn, acc, el0, el1;
    int sz0, n;
    #2;
    sz0  = mq.size();
    src  = (ph == 0) ? lst : own;
    popn = m0_rdv && sz0 > 0 && mq[0].left == 1;
    e_rd = 1'b0; e_wr = 1'b0; e_wait = 2'b11; e_rdv = 2'b00;
    if (!reset) begin
      if (m0_rdv && sz0 > 0) e_rdv[mq[0].id] = 1'b1;
      if (ph == 1) begin
        w = s_write[own];
        r = s_read[own] && !w;
        stall = r && sz0 == Depth && !popn;
        e_wr = w;
        e_rd = r && !stall;
        e_wait[own] = stall || m0_wait;
      end else if (ph == 2) begin
        e_wr = s_write[own];
        e_wait[own] = m0_wait;
      end
    end
    cmp("m0_read", m0_read, e_rd);
    cmp("m0_write", m0_write, e_wr);
    cmp("s0_waitrequest", s0_wait, e_wait[0]);
    cmp("s1_waitrequest", s1_wait, e_wait[1]);
    cmp("s0_readdatavalid", s0_rdv, e_rdv[0]);
    cmp("s1_readdatavalid", s1_rdv, e_rdv[1]);
    cmp("err_orphan_rdv", err, merr);
    cmp("m0_address", m0_address, s_addr[src]);
    cmp("m0_burstcount", m0_bc, s_bc[src]);
    cmp("m0_writedata", m0_wdata, s_wdata[src]);
    cmp("m0_be", m0_be, s_be[src]);
    cmp("s0_readdata", s0_rdata, m0_rdata);
    cmp("s1_readdata", s1_rdata, m0_rdata);
    if (reset) begin
      ph = 0; own = 1'b0; lst = 1'b1; wleft = 0; merr = 1'b0; mq.delete();
    end else begin
      if (m0_rdv) begin
        if (sz0 == 0) merr = 1'b1;
        else begin
          mq[0].left--;
          if (mq[0].left == 0) void'(mq.pop_front());
        end
      end
      acc = (e_rd || e_wr) && !m0_wait;
      n = (s_bc[own] == 0) ? 1 : int'(s_bc[own]);
      if (ph == 0) begin
        el0 = s_write[0] || (s_read[0] && sz0 < Depth);
        el1 = s_write[1] || (s_read[1] && sz0 < Depth);
        if (el0 || el1) begin
          own = (el0 && el1) ? !lst : el1;
          ph = 1;
        end
      end else if (ph == 1 && acc) begin
        if (e_rd) begin
          mq.push_back('{id: own, left: n});
          lst = own; ph = 0;
        end else if (n == 1) begin
          lst = own; ph = 0;
        end else begin
          wleft = n - 1; ph = 2;
        end
      end else if (ph == 2 && acc) begin
        wleft--;
        if (wleft == 0) begin
          lst = own; ph = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    check();
    tick();
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (!rq_act[n] && $urandom_range(0, 3) == 0) begin
        rq_act[n] = 1'b1; rq_first[n] = 1'b1;
        rq_kind[n] = $urandom_range(0, 2);
        rq_bc[n] = $urandom_range(0, 4);
        s_addr[n] = AW'($urandom);
        s_bc[n] = 7'(rq_bc[n]);
      end
      s_wdata[n] = {$urandom, $urandom};
      s_be[n] = BW'($urandom);
      if (!rq_act[n]) begin
        s_read[n] = 1'b0; s_write[n] = 1'b0;
      end else if (rq_first[n]) begin
        s_read[n] = (rq_kind[n] != 1);
        s_write[n] = (rq_kind[n] != 0);
      end else begin
        s_read[n] = 1'b0;
        s_write[n] = ($urandom_range(0, 4) != 0);
      end
    end
    m0_wait  = ($urandom_range(0, 9) < 3);
    m0_rdv   = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
    m0_rdata = {$urandom, $urandom};
    reset    = ($urandom_range(0, 399) == 0);
  endtask

  task automatic req_update();
    for (int n = 0; n < 2; n++) begin
      if (reset) rq_act[n] = 1'b0;
      else if ((s_read[n] || s_write[n]) && !e_wait[n]) begin
        if (!rq_first[n]) begin
          rq_left[n]--;
          if (rq_left[n] == 0) rq_act[n] = 1'b0;
        end else if (rq_kind[n] == 0) begin
          rq_act[n] = 1'b0;
        end else begin
          rq_first[n] = 1'b0;
          rq_left[n] = ((rq_bc[n] == 0) ? 1 : rq_bc[n]) - 1;
          if (rq_left[n] == 0) rq_act[n] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; s_addr = '0; s_read = '0; s_write = '0; s_wdata = '0; s_be = '0; s_bc = '0;
    m0_wait = 1'b0; m0_rdv = 1'b0; m0_rdata = '0;
    tick(); tick();

    // Reset state, with a stray beat during reset
    check();
    cmp("lit_reset_wait", {s1_wait, s0_wait}, 2'b11);
    cmp("lit_reset_m0_rw", {m0_read, m0_write}, 2'b00);
    cmp("lit_reset_err", err, 1'b0);
    tick();
    m0_rdv = 1'b1;
    check();
    cmp("lit_reset_rdv", {s1_rdv, s0_rdv}, 2'b00);
    tick();
    m0_rdv = 1'b0; reset = 1'b0;

    // Both read at once: s0 wins first, s1 next
    s_read = 2'b11; s_addr[0] = 27'h100; s_addr[1] = 27'h200; s_bc[0] = 7'd1; s_bc[1] = 7'd1;
    check(); cmp("lit_tie_c1_rd", m0_read, 1'b0); tick();
    check(); cmp("lit_tie_c2_rd", m0_read, 1'b1); cmp("lit_tie_c2_addr", m0_address, 27'h100);
    cmp("lit_tie_c2_wait", {s1_wait, s0_wait}, 2'b10); tick();
    s_read[0] = 1'b0;
    check(); cmp("lit_tie_c3_rd", m0_read, 1'b0); tick();
    check(); cmp("lit_tie_c4_rd", m0_read, 1'b1); cmp("lit_tie_c4_addr", m0_address, 27'h200);
    cmp("lit_tie_c4_wait", {s1_wait, s0_wait}, 2'b01); tick();
    s_read[1] = 1'b0;
    m0_rdv = 1'b1; m0_rdata = 64'hD0;
    check(); cmp("lit_d0_rdv", {s1_rdv, s0_rdv}, 2'b01); cmp("lit_d0_data", s0_rdata, 64'hD0);
    tick();
    m0_rdata = 64'hD1;
    check(); cmp("lit_d1_rdv", {s1_rdv, s0_rdv}, 2'b10); cmp("lit_d1_data", s1_rdata, 64'hD1);
    tick();
    m0_rdv = 1'b0;

    // s1 write burst of 4 with s0 read waiting
    s_write[1] = 1'b1; s_bc[1] = 7'd4; s_addr[1] = 27'h300; s_wdata[1] = 64'hA5A5_0000;
    check(); cmp("lit_wb_arb", m0_write, 1'b0); tick();
    s_read[0] = 1'b1; s_addr[0] = 27'h400; s_bc[0] = 7'd1;
    for (int i = 0; i < 4; i++) begin
      s_wdata[1] = 64'hA5A5_0000 + 64'(i);
      check();
      cmp("lit_wb_write", m0_write, 1'b1);
      cmp("lit_wb_data", m0_wdata, 64'hA5A5_0000 + 64'(i));
      cmp("lit_wb_wait", {s1_wait, s0_wait}, 2'b01);
      tick();
    end
    s_write[1] = 1'b0;
    check(); cmp("lit_wb_idle", {m0_read, m0_write, s0_wait}, 3'b001); tick();
    check(); cmp("lit_wb_rd", m0_read, 1'b1); cmp("lit_wb_rd_addr", m0_address, 27'h400); tick();
    s_read[0] = 1'b0;
    m0_rdv = 1'b1;
    check(); cmp("lit_wb_rdv", {s1_rdv, s0_rdv}, 2'b01); tick();
    m0_rdv = 1'b0;

    // Downstream stall during s0 read command
    s_read[0] = 1'b1; s_addr[0] = 27'h500; s_bc[0] = 7'd2; m0_wait = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      check();
      cmp("lit_st_wait", s0_wait, 1'b1);
      cmp("lit_st_rd", m0_read, 1'b1);
      cmp("lit_st_addr", m0_address, 27'h500);
      tick();
    end
    m0_wait = 1'b0;
    check(); cmp("lit_st_release", {m0_read, s0_wait}, 2'b10); tick();
    s_read[0] = 1'b0;
    m0_rdv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check(); cmp("lit_st_beat", {s1_rdv, s0_rdv}, 2'b01); tick();
    end
    m0_rdv = 1'b0;

    // Fill the read FIFO; the 9th read waits for a pop
    s_read[0] = 1'b1; s_addr[0] = 27'h600; s_bc[0] = 7'd1;
    for (int k = 0; k < Depth; k++) begin
      cyc();
      check(); cmp("lit_fill_rd", m0_read, 1'b1); tick();
    end
    for (int i = 0; i < 3; i++) begin
      check(); cmp("lit_full_stall", {m0_read, s0_wait}, 2'b01); tick();
    end
    m0_rdv = 1'b1;
    check(); cmp("lit_full_pop", {s0_rdv, m0_read}, 2'b10); tick();
    m0_rdv = 1'b0;
    check(); cmp("lit_full_arb", m0_read, 1'b0); tick();
    check(); cmp("lit_full_issue", m0_read, 1'b1); tick();
    s_read[0] = 1'b0;
    m0_rdv = 1'b1;
    for (int k = 0; k < Depth; k++) begin
      check(); cmp("lit_drain", {s1_rdv, s0_rdv}, 2'b01); tick();
    end
    m0_rdv = 1'b0;

    // Orphan response is dropped and flagged until reset
    m0_rdv = 1'b1;
    check(); cmp("lit_orph_rdv", {s1_rdv, s0_rdv}, 2'b00); cmp("lit_orph_pre", err, 1'b0); tick();
    m0_rdv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check(); cmp("lit_orph_sticky", err, 1'b1); tick();
    end
    reset = 1'b1; cyc(); reset = 1'b0;
    check(); cmp("lit_orph_clear", err, 1'b0); tick();

    // Burstcount 0 write and read each count as one beat
    s_write[0] = 1'b1; s_bc[0] = 7'd0; s_addr[0] = 27'h700;
    cyc();
    check(); cmp("lit_bc0_wr", {m0_write, s0_wait}, 2'b10); tick();
    s_write[0] = 1'b0;
    check(); cmp("lit_bc0_idle", m0_write, 1'b0); tick();
    s_read[1] = 1'b1; s_bc[1] = 7'd0; s_addr[1] = 27'h780;
    cyc();
    check(); cmp("lit_bc0_rd", m0_read, 1'b1); cmp("lit_bc0_bc", m0_bc, 7'd0); tick();
    s_read[1] = 1'b0;
    m0_rdv = 1'b1;
    check(); cmp("lit_bc0_rdv", {s1_rdv, s0_rdv}, 2'b10); tick();
    cmp("lit_model_empty", 64'(mq.size()), 64'd0);
    check(); cmp("lit_bc0_extra", {s1_rdv, s0_rdv}, 2'b00); tick();
    m0_rdv = 1'b0;
    check(); cmp("lit_bc0_err", err, 1'b1); tick();
    reset = 1'b1; cyc(); reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 2; n++) rq_act[n] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      drive();
      check();
      req_update();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
